// File: rtl/life_pkg.sv
// Shared types and constants for the Game-of-Life cell update controller.
// The next-state rule lives here so the datapath and any reference model share one definition.
package life_pkg;

  localparam int NEIGHBOURS_CNT = 8;
  localparam int SLOT_CNT       = 9;
  localparam int CNT_W          = 4;
  localparam int SLOT_W         = $clog2(SLOT_CNT);
  localparam int NBR_W          = $clog2(NEIGHBOURS_CNT);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    DRAIN,
    WRITE,
    DONE
  } state_t;

  // Conway rule: birth on exactly 3 neighbours, survival on 2 or 3.
  function automatic logic next_cell_state(input logic self, input logic [CNT_W-1:0] count);
    return (count == CNT_W'(3)) || (self && (count == CNT_W'(2)));
  endfunction

endpackage

// File: rtl/cell_update_ctrl_if.sv
// Control handshake and field-buffer read/write bus of the cell update controller.
// The master modport is the controller side; the slave modport is the requester/memory side.
interface cell_update_ctrl_if #(
  parameter int FIELD_W = 4,
  parameter int FIELD_H = 3
);

  localparam int X_W = $clog2(FIELD_W);
  localparam int Y_W = $clog2(FIELD_H);

  logic           i_start;
  logic           o_busy;
  logic           o_done;
  logic           o_rd_en;
  logic [X_W-1:0] o_rd_x_adr;
  logic [Y_W-1:0] o_rd_y_adr;
  logic           i_rd_data;
  logic           o_wr_en;
  logic [X_W-1:0] o_wr_x_adr;
  logic [Y_W-1:0] o_wr_y_adr;
  logic           o_wr_data;

  modport master (
    input  i_start, i_rd_data,
    output o_busy, o_done,
    output o_rd_en, o_rd_x_adr, o_rd_y_adr,
    output o_wr_en, o_wr_x_adr, o_wr_y_adr, o_wr_data
  );

  modport slave (
    output i_start, i_rd_data,
    input  o_busy, o_done,
    input  o_rd_en, o_rd_x_adr, o_rd_y_adr,
    input  o_wr_en, o_wr_x_adr, o_wr_y_adr, o_wr_data
  );

endinterface

// File: rtl/get_nbrs_address.sv
// Addresses of the eight neighbours of a cell, ordered top-left .. bottom-right,
// with a relevance bit that is cleared for neighbours falling outside the field.
module get_nbrs_address
  import life_pkg::*;
#(
  parameter  int FIELD_W = 4,
  parameter  int FIELD_H = 3,
  localparam int X_W     = $clog2(FIELD_W),
  localparam int Y_W     = $clog2(FIELD_H)
) (
  input  logic [X_W-1:0]                     i_x_adr,
  input  logic [Y_W-1:0]                     i_y_adr,
  output logic [NEIGHBOURS_CNT-1:0][X_W-1:0] o_nbrs_x_adr,
  output logic [NEIGHBOURS_CNT-1:0][Y_W-1:0] o_nbrs_y_adr,
  output logic [NEIGHBOURS_CNT-1:0]          o_nbrs_rlvnt
);

  always_comb begin
    // NOTE: every combinational output gets a default before any branch so no latch is inferred.
    o_nbrs_x_adr = '0;
    o_nbrs_y_adr = '0;
    o_nbrs_rlvnt = '0;
    for (int k = 0; k < NEIGHBOURS_CNT; k++) begin
      automatic int win = (k < 4) ? k : k + 1;  // 3x3 window index, centre (4) skipped
      automatic int nx  = int'(i_x_adr) + (win % 3) - 1;
      automatic int ny  = int'(i_y_adr) + (win / 3) - 1;
      if (nx >= 0 && nx < FIELD_W && ny >= 0 && ny < FIELD_H) begin
        o_nbrs_rlvnt[k] = 1'b1;
        o_nbrs_x_adr[k] = X_W'(nx);
        o_nbrs_y_adr[k] = Y_W'(ny);
      end
    end
  end

endmodule

// File: rtl/cell_update_ctrl.sv
// Sequences one Game-of-Life generation: per cell, read self and in-field neighbours
// over nine slots, drain the last read, then write the next state (11 cycles per cell).
module cell_update_ctrl
  import life_pkg::*;
#(
  parameter int FIELD_W = 4,
  parameter int FIELD_H = 3
) (
  input  logic               i_clk,
  input  logic               i_rst,
  cell_update_ctrl_if.master bus
);

  localparam int X_W = $clog2(FIELD_W);
  localparam int Y_W = $clog2(FIELD_H);

  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SLOT_CNT - 1);
  localparam logic [X_W-1:0]    LAST_X    = X_W'(FIELD_W - 1);
  localparam logic [Y_W-1:0]    LAST_Y    = Y_W'(FIELD_H - 1);

  state_t            state_q, state_d;
  logic [SLOT_W-1:0] slot_q;
  logic [X_W-1:0]    x_q;
  logic [Y_W-1:0]    y_q;
  logic [CNT_W-1:0]  count_q;
  logic              self_q;
  logic              rd_vld_q;
  logic [SLOT_W-1:0] rd_slot_q;

  logic [NEIGHBOURS_CNT-1:0][X_W-1:0] nbrs_x_adr;
  logic [NEIGHBOURS_CNT-1:0][Y_W-1:0] nbrs_y_adr;
  logic [NEIGHBOURS_CNT-1:0]          nbrs_rlvnt;
  logic [NBR_W-1:0]                   nbr_idx;
  logic                               rd_en;
  logic                               last_cell;

  get_nbrs_address #(
    .FIELD_W (FIELD_W),
    .FIELD_H (FIELD_H)
  ) u_nbrs (
    .i_x_adr      (x_q),
    .i_y_adr      (y_q),
    .o_nbrs_x_adr (nbrs_x_adr),
    .o_nbrs_y_adr (nbrs_y_adr),
    .o_nbrs_rlvnt (nbrs_rlvnt)
  );

  // Slot k (1..8) addresses neighbour k-1; slot 0 is the cell itself.
  assign nbr_idx   = NBR_W'(slot_q - SLOT_W'(1));
  assign rd_en     = (state_q == READ) && ((slot_q == '0) || nbrs_rlvnt[nbr_idx]);
  assign last_cell = (x_q == LAST_X) && (y_q == LAST_Y);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.i_start) state_d = READ;
      READ:    if (slot_q == LAST_SLOT) state_d = DRAIN;
      DRAIN:   state_d = WRITE;
      WRITE:   state_d = last_cell ? DONE : READ;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      slot_q    <= '0;
      x_q       <= '0;
      y_q       <= '0;
      count_q   <= '0;
      self_q    <= 1'b0;
      rd_vld_q  <= 1'b0;
      rd_slot_q <= '0;
    end else begin
      state_q   <= state_d;
      rd_vld_q  <= rd_en;
      rd_slot_q <= slot_q;

      if (state_q == READ && slot_q != LAST_SLOT) slot_q <= slot_q + SLOT_W'(1);
      else                                        slot_q <= '0;

      // Read data belongs to the slot issued one cycle earlier; skipped slots contribute nothing.
      if (state_q == READ && slot_q == '0)        count_q <= '0;
      else if (rd_vld_q && rd_slot_q != '0)       count_q <= count_q + CNT_W'(bus.i_rd_data);

      if (rd_vld_q && rd_slot_q == '0) self_q <= bus.i_rd_data;

      if (state_q == WRITE) begin
        if (x_q == LAST_X) begin
          x_q <= '0;
          y_q <= (y_q == LAST_Y) ? '0 : y_q + Y_W'(1);
        end else begin
          x_q <= x_q + X_W'(1);
        end
      end
    end
  end

  // Outputs are forced low while reset is held so an abort never leaks a strobe.
  always_comb begin
    bus.o_busy     = 1'b0;
    bus.o_done     = 1'b0;
    bus.o_rd_en    = 1'b0;
    bus.o_rd_x_adr = '0;
    bus.o_rd_y_adr = '0;
    bus.o_wr_en    = 1'b0;
    bus.o_wr_x_adr = '0;
    bus.o_wr_y_adr = '0;
    bus.o_wr_data  = 1'b0;
    if (!i_rst) begin
      bus.o_busy  = (state_q != IDLE);
      bus.o_done  = (state_q == DONE);
      bus.o_rd_en = rd_en;
      if (rd_en) begin
        bus.o_rd_x_adr = (slot_q == '0) ? x_q : nbrs_x_adr[nbr_idx];
        bus.o_rd_y_adr = (slot_q == '0) ? y_q : nbrs_y_adr[nbr_idx];
      end
      if (state_q == WRITE) begin
        bus.o_wr_en    = 1'b1;
        bus.o_wr_x_adr = x_q;
        bus.o_wr_y_adr = y_q;
        bus.o_wr_data  = next_cell_state(self_q, count_q);
      end
    end
  end

endmodule

// File: tb/tb_cell_update_ctrl.sv
// Directed bench for cell_update_ctrl on a 4x3 field: a one-cycle-latency memory model
// serves reads, a monitor collects writes, read pulses per cell and done pulses.
module tb_cell_update_ctrl;

  localparam int FW = 4;
  localparam int FH = 3;
  localparam int NC = FW * FH;

  logic clk = 1'b0;
  logic rst;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [NC-1:0] cur_field;
  logic [NC-1:0] nxt_field;
  int            wr_cnt   = 0;
  int            done_cnt = 0;
  int            done_cyc = 0;
  int            rd_run   = 0;
  int            cell_rd [NC];
  int            start_cyc;
  int            wr_base, done_base, wr_base2;

  cell_update_ctrl_if #(.FIELD_W(FW), .FIELD_H(FH)) bus ();

  cell_update_ctrl #(
    .FIELD_W (FW),
    .FIELD_H (FH)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Current-field memory: data appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (bus.o_rd_en)
      bus.i_rd_data <= cur_field[int'(bus.o_rd_y_adr) * FW + int'(bus.o_rd_x_adr)];
  end

  always @(negedge clk) begin
    if (bus.o_rd_en) rd_run <= rd_run + 1;
    if (bus.o_wr_en) begin
      nxt_field[int'(bus.o_wr_y_adr) * FW + int'(bus.o_wr_x_adr)] <= bus.o_wr_data;
      cell_rd[int'(bus.o_wr_y_adr) * FW + int'(bus.o_wr_x_adr)]   <= rd_run;
      rd_run <= 0;
      wr_cnt <= wr_cnt + 1;
    end
    if (bus.o_done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"},    32'(bus.o_busy),     0);
    check({tag, "_done"},    32'(bus.o_done),     0);
    check({tag, "_rd_en"},   32'(bus.o_rd_en),    0);
    check({tag, "_wr_en"},   32'(bus.o_wr_en),    0);
    check({tag, "_wr_data"}, 32'(bus.o_wr_data),  0);
    check({tag, "_rd_x"},    32'(bus.o_rd_x_adr), 0);
    check({tag, "_rd_y"},    32'(bus.o_rd_y_adr), 0);
    check({tag, "_wr_x"},    32'(bus.o_wr_x_adr), 0);
    check({tag, "_wr_y"},    32'(bus.o_wr_y_adr), 0);
  endtask

  task automatic do_start();
    @(negedge clk);
    bus.i_start = 1'b1;
    start_cyc   = cyc;
    @(negedge clk);
    bus.i_start = 1'b0;
  endtask

  task automatic wait_done(input int base, input string tag);
    int n = 0;
    while (done_cnt == base && n < 300) begin
      @(posedge clk);
      n++;
    end
    check(tag, done_cnt - base, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    bus.i_start = 1'b1;
    cur_field   = '0;
    repeat (3) @(negedge clk);
    check_quiet("reset");
    rst         = 1'b0;
    bus.i_start = 1'b0;
    @(negedge clk);
    check("idle_after_reset_busy", 32'(bus.o_busy), 0);

    // Horizontal blinker on row 1 becomes a vertical blinker at x=1.
    cur_field = 12'h070;
    wr_base   = wr_cnt;
    done_base = done_cnt;
    do_start();
    check("blinker_busy", 32'(bus.o_busy), 1);
    wait_done(done_base, "blinker_done_seen");
    repeat (2) @(negedge clk);
    check("blinker_field",   32'(nxt_field), 32'h222);
    check("blinker_writes",  wr_cnt - wr_base, 12);
    check("blinker_latency", done_cyc - start_cyc - 1, 132);
    check("rd_pulses_0_0",   cell_rd[0], 4);
    check("rd_pulses_1_1",   cell_rd[5], 9);
    check("rd_pulses_1_0",   cell_rd[1], 6);
    check("rd_pulses_3_2",   cell_rd[11], 4);
    check("blinker_idle_busy", 32'(bus.o_busy), 0);

    // Full field: only corners keep exactly three neighbours.
    cur_field = '1;
    wr_base   = wr_cnt;
    done_base = done_cnt;
    do_start();
    wait_done(done_base, "full_done_seen");
    repeat (2) @(negedge clk);
    check("full_field",   32'(nxt_field), 32'h909);
    check("full_writes",  wr_cnt - wr_base, 12);
    check("full_latency", done_cyc - start_cyc - 1, 132);

    // Stable 2x2 block; a second start while busy must be ignored.
    cur_field = 12'h066;
    wr_base   = wr_cnt;
    done_base = done_cnt;
    do_start();
    repeat (20) @(negedge clk);
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    wait_done(done_base, "block_done_seen");
    repeat (30) @(negedge clk);
    check("block_field",     32'(nxt_field), 32'h066);
    check("block_writes",    wr_cnt - wr_base, 12);
    check("block_done_once", done_cnt - done_base, 1);
    check("block_idle_busy", 32'(bus.o_busy), 0);

    // Reset in cycle 50 of a generation: four cells written, then silence.
    cur_field = 12'h070;
    wr_base   = wr_cnt;
    done_base = done_cnt;
    do_start();
    repeat (50) @(posedge clk);
    @(negedge clk);
    check("abort_busy_before", 32'(bus.o_busy), 1);
    check("abort_writes_before", wr_cnt - wr_base, 4);
    rst      = 1'b1;
    wr_base2 = wr_cnt;
    @(negedge clk);
    check_quiet("abort");
    rst = 1'b0;
    repeat (150) @(negedge clk);
    check("abort_no_writes", wr_cnt - wr_base2, 0);
    check("abort_no_done",   done_cnt - done_base, 0);
    check("abort_idle_busy", 32'(bus.o_busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
